// File: rtl/definitions.sv
// definitions: shared FSM state type, sizing constants and branch-target table for instr_fetch
//   PC_W           program-counter width
//   LUT_DEPTH      number of branch-target entries
//   state_t        IDLE / RUN / HALTED
//   BRANCH_TARGETS branch-target address per LUT index
package definitions;
   localparam int PC_W = 10;
   localparam int LUT_DEPTH = 32;
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   localparam logic [PC_W-1:0] BRANCH_TARGETS [LUT_DEPTH] = '{
      10'd0,   10'd100, 10'd200, 10'd40,   10'd1020, 10'd7,   10'd512, 10'd1023,
      10'd16,  10'd300, 10'd333, 10'd64,   10'd900,  10'd128, 10'd5,   10'd777,
      10'd256, 10'd10,  10'd600, 10'd1000, 10'd20,   10'd450, 10'd999, 10'd31,
      10'd700, 10'd2,   10'd850, 10'd65,   10'd400,  10'd1001, 10'd3,  10'd511
   };
endpackage

// File: rtl/branch_lut.sv
// branch_lut: combinational branch-target lookup
//   idx     LUT index taken from the current instruction
//   target  branch-target program counter
module branch_lut import definitions::*; (
   input  logic [$clog2(LUT_DEPTH)-1:0] idx,
   output logic [PC_W-1:0]              target
);
   assign target = BRANCH_TARGETS[idx];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction register and run/halt control
//   CLK, reset           clock, synchronous active-high reset
//   Start, Stall         go pulse, hold-this-cycle
//   Branch, Taken, Halt  decode of the current Instruction from Control
//   LutIdx               branch-target index of the current Instruction
//   RomData / PC         instruction-ROM read data / address
//   Instruction          registered instruction, live when InstrValid
//   Done                 program halted
//   CycleCount           saturating count of cycles spent running
module instr_fetch #(
   parameter int PC_W = definitions::PC_W,
   parameter int LUT_DEPTH = definitions::LUT_DEPTH
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic                         Start,
   input  logic                         Stall,
   input  logic                         Branch,
   input  logic                         Taken,
   input  logic [$clog2(LUT_DEPTH)-1:0] LutIdx,
   input  logic                         Halt,
   input  logic [8:0]                   RomData,
   output logic [PC_W-1:0]              PC,
   output logic [8:0]                   Instruction,
   output logic                         InstrValid,
   output logic                         Done,
   output logic [15:0]                  CycleCount
);
   import definitions::*;
   state_t state;
   logic [PC_W-1:0] target;
   branch_lut u_lut (.idx(LutIdx), .target(target));
   always_ff @(posedge CLK)
      if (reset) begin
         state <= IDLE;
         PC <= '0;
         Instruction <= '0;
         InstrValid <= 1'b0;
         Done <= 1'b0;
         CycleCount <= '0;
      end else
         case (state)
            IDLE: if (Start) state <= RUN;
            RUN: begin
               if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 1'b1;
               // decode inputs only count when the instruction is live; halt beats a taken branch
               if (!Stall) begin
                  if (InstrValid && Halt) begin
                     state <= HALTED;
                     InstrValid <= 1'b0;
                     Done <= 1'b1;
                  end else if (InstrValid && Branch && Taken) begin
                     Instruction <= RomData;
                     PC <= target;
                     InstrValid <= 1'b0;
                  end else begin
                     Instruction <= RomData;
                     PC <= PC + 1'b1;
                     InstrValid <= 1'b1;
                  end
               end
            end
            HALTED: if (Start) begin
               state <= RUN;
               PC <= '0;
               CycleCount <= '0;
               Done <= 1'b0;
               InstrValid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random-program scoreboard bench for instr_fetch
module tb_instr_fetch;
   logic CLK = 0, reset = 1, Start = 0, Stall = 0;
   logic Branch, Taken, Halt;
   logic [4:0] LutIdx;
   logic [8:0] RomData, Instruction;
   logic [9:0] PC;
   logic InstrValid, Done;
   logic [15:0] CycleCount;
   logic [8:0] rom [1024];
   int lut [32] = '{0, 100, 200, 40, 1020, 7, 512, 1023, 16, 300, 333, 64, 900, 128, 5, 777,
                    256, 10, 600, 1000, 20, 450, 999, 31, 700, 2, 850, 65, 400, 1001, 3, 511};
   typedef struct {int addr; logic [8:0] instr;} ent_t;
   ent_t q[$];
   ent_t e;
   bit armed = 0;
   int errors = 0, checks = 0;

   instr_fetch dut (.CLK(CLK), .reset(reset), .Start(Start), .Stall(Stall), .Branch(Branch),
      .Taken(Taken), .LutIdx(LutIdx), .Halt(Halt), .RomData(RomData), .PC(PC),
      .Instruction(Instruction), .InstrValid(InstrValid), .Done(Done), .CycleCount(CycleCount));

   always #5 CLK = ~CLK;

   // Control decode: 11x = branch, bit5 = taken, 111 = halt, bits 4:0 = LUT index
   assign Branch = Instruction[8:7] == 2'b11;
   assign Taken = Instruction[5];
   assign Halt = &Instruction[8:6];
   assign LutIdx = Instruction[4:0];
   assign RomData = rom[PC];

   task automatic chk(input string n, input int a, input int x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, a, x);
      end
   endtask

   // architectural execution trace: which instructions run, in order, and where it halts
   task automatic build(input int cap, output bit halts, output int taken, output int hpc);
      int a = 0;
      logic [8:0] w;
      q.delete();
      halts = 0;
      taken = 0;
      hpc = 0;
      for (int n = 0; n < cap && !halts; n++) begin
         w = rom[a];
         q.push_back('{addr: a, instr: w});
         if (w[8:6] == 3'b111) begin
            halts = 1;
            hpc = (a + 1) % 1024;
         end else if (w[8:7] == 2'b11 && w[5]) begin
            a = lut[w[4:0]];
            taken++;
         end else a = (a + 1) % 1024;
      end
   endtask

   // an instruction is consumed on each edge where it is live and not stalled
   always @(negedge CLK)
      if (armed && !reset && InstrValid && !Stall) begin
         if (q.size() == 0) chk("sb_empty", 1, 0);
         else begin
            e = q.pop_front();
            chk("instr", int'(Instruction), int'(e.instr));
            chk("pc", int'(PC), (e.addr + 1) % 1024);
         end
      end

   task automatic chk_reset(input string n);
      chk({n, "_pc"}, int'(PC), 0);
      chk({n, "_instr"}, int'(Instruction), 0);
      chk({n, "_valid"}, int'(InstrValid), 0);
      chk({n, "_done"}, int'(Done), 0);
      chk({n, "_cyc"}, int'(CycleCount), 0);
      @(posedge CLK); #1;
      chk({n, "_idle"}, int'(PC) + int'(InstrValid), 0);
   endtask

   task automatic do_reset();
      reset = 1;
      @(posedge CLK); #1;
      reset = 0;
      chk_reset("rst");
   endtask

   task automatic run_prog(input int cap, input int sp, input bit from_halt, output bit halts);
      int taken, hpc, len, ticks, stalls;
      build(cap, halts, taken, hpc);
      len = q.size();
      armed = 1;
      Start = 1;
      @(posedge CLK); #1;
      Start = 0;
      if (from_halt) begin
         chk("restart_pc", int'(PC), 0);
         chk("restart_cyc", int'(CycleCount), 0);
         chk("restart_done", int'(Done), 0);
         chk("restart_valid", int'(InstrValid), 0);
      end
      ticks = 0;
      stalls = 0;
      while (ticks < 20000 && (halts ? !Done : q.size() > 0)) begin
         Stall = $urandom_range(0, 99) < sp;
         Start = $urandom_range(0, 15) == 0;
         @(posedge CLK);
         ticks++;
         stalls += int'(Stall);
         #1;
      end
      armed = 0;
      Stall = 0;
      Start = 0;
      chk("timeout", int'(ticks < 20000), 1);
      if (halts) begin
         chk("done", int'(Done), 1);
         chk("halt_pc", int'(PC), hpc);
         chk("cyc", int'(CycleCount), ticks);
         chk("cycles", ticks, len + taken + 1 + stalls);
         chk("drained", q.size(), 0);
         repeat (3) begin
            Stall = 1'($urandom);
            @(posedge CLK); #1;
         end
         Stall = 0;
         chk("held_pc", int'(PC), hpc);
         chk("held_cyc", int'(CycleCount), ticks);
         chk("held_valid", int'(InstrValid), 0);
         chk("held_done", int'(Done), 1);
      end else begin
         Stall = 1;
         reset = 1;
         @(posedge CLK); #1;
         reset = 0;
         Stall = 0;
         chk_reset("midrun");
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit h;
      for (int i = 0; i < 1024; i++) rom[i] = {1'b0, 8'(i)};
      repeat (2) @(posedge CLK);
      #1;
      reset = 0;
      chk_reset("por");
      reset = 1;
      Start = 1;
      @(posedge CLK); #1;
      reset = 0;
      Start = 0;
      chk_reset("rst_start");
      // straight line, taken branch at 5 via LUT[3], halt+taken at 45
      rom[5] = 9'h1A3;
      rom[45] = 9'h1E3;
      run_prog(100, 0, 0, h);
      chk("progA_halts", int'(h), 1);
      run_prog(100, 30, 1, h);
      // loop through 1020..1023 wrapping to 0, ended by a stalled reset
      for (int i = 0; i < 1024; i++) rom[i] = {1'b0, 8'($urandom)};
      rom[4] = 9'h1A4;
      run_prog(40, 20, 0, h);
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 1024; i++) begin
            int p = $urandom_range(0, 99);
            rom[i] = p < 1 ? {3'b111, 6'($urandom)} :
                     p < 12 ? {3'b110, 1'($urandom_range(0, 9) < 6), 5'($urandom)} :
                     {1'b0, 8'($urandom)};
         end
         do_reset();
         run_prog(400, $urandom_range(0, 40), 0, h);
         if (h) run_prog(400, $urandom_range(0, 40), 1, h);
         else do_reset();
      end
      // saturation: stall from the first RUN cycle so only the counter moves
      do_reset();
      Start = 1;
      @(posedge CLK); #1;
      Start = 0;
      Stall = 1;
      repeat (65534) @(posedge CLK);
      #1;
      chk("sat_fffe", int'(CycleCount), 16'hFFFE);
      chk("sat_pc", int'(PC), 0);
      chk("sat_valid", int'(InstrValid), 0);
      @(posedge CLK); #1;
      chk("sat_ffff", int'(CycleCount), 16'hFFFF);
      repeat (5) @(posedge CLK);
      #1;
      chk("sat_hold", int'(CycleCount), 16'hFFFF);
      Stall = 0;
      do_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
